// File: rtl/media_bloco_q44.sv
// media_bloco_q44: block averager for Q4.4 samples from the adder/subtractor stage.
// Overflowed samples are saturated to the correct extreme, 2^LOG2N samples are summed,
// and the rounded mean plus the count of saturated samples is held until accepted.
module media_bloco_q44 #(
    parameter int LOG2N = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_result,
    input  logic               in_overflow,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_mean,
    output logic [LOG2N:0]     out_sat_count
);

    localparam int ACC_W = 8 + LOG2N;
    localparam int CNT_W = LOG2N + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((2 ** LOG2N) - 1);
    // Half an LSB of the mean, added before the shift so ties round toward +infinity.
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (LOG2N - 1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         sat_q, sat_d;
    logic [7:0]               mean_q, mean_d;
    logic [CNT_W-1:0]         out_sat_q, out_sat_d;

    logic [7:0]               sample_fix;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_rounded;
    logic signed [ACC_W-1:0]  mean_full;
    logic [CNT_W-1:0]         sat_sum;
    logic                     accept;

    // Correct, extend and sum the incoming sample; derive the rounded mean from the running sum.
    always_comb begin
        // An overflowed result has the wrong sign bit: a negative-looking result came
        // from a positive overflow, so it saturates to +max, and vice versa.
        if (in_overflow) begin
            sample_fix = in_result[7] ? 8'h7F : 8'h80;
        end else begin
            sample_fix = in_result;
        end
        sample_ext  = {{LOG2N{sample_fix[7]}}, sample_fix};
        acc_sum     = acc_q + sample_ext;
        // The sum of N samples plus HALF stays below 2^(ACC_W-1), so this add cannot wrap.
        acc_rounded = acc_sum + HALF;
        mean_full   = acc_rounded >>> LOG2N;
        sat_sum     = sat_q + CNT_W'(in_overflow);
        accept      = (state_q == ACCUM) && in_valid;
    end

    // Next-state and datapath updates; every _d defaults to its current value.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned, which would infer a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        mean_d    = mean_q;
        out_sat_d = out_sat_q;
        case (state_q)
            IDLE: begin
                state_d = ACCUM;
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    sat_d = sat_sum;
                    if (cnt_q == LAST_IDX) begin
                        mean_d    = mean_full[7:0];
                        out_sat_d = sat_sum;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= '0;
            mean_q    <= '0;
            out_sat_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            mean_q    <= mean_d;
            out_sat_q <= out_sat_d;
        end
    end

    // Handshake flags decode straight from the state register, never from inputs.
    assign in_ready      = (state_q == ACCUM);
    assign out_valid     = (state_q == HOLD);
    assign out_mean      = mean_q;
    assign out_sat_count = out_sat_q;

endmodule

// File: tb/tb_media_bloco_q44.sv
// Directed testbench for media_bloco_q44 with LOG2N=3 (8 samples per block).
// Inputs change and outputs are sampled on the falling edge.
module tb_media_bloco_q44;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic       in_overflow;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_mean;
    logic [3:0] out_sat_count;

    int total = 0;
    int bad   = 0;

    media_bloco_q44 #(.LOG2N(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_overflow   (in_overflow),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_mean      (out_mean),
        .out_sat_count (out_sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one sample, waiting (bounded) for in_ready; returns at the falling edge after the accept.
    task automatic push(input logic [7:0] d, input logic ovf);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL push_wait in_ready=%b required=1", in_ready);
        end
        in_valid    = 1'b1;
        in_result   = d;
        in_overflow = ovf;
        @(negedge clk);
        in_valid    = 1'b0;
    endtask

    // Handshake the held result away in one cycle.
    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_result = 8'h00; in_overflow = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_mean, out_sat_count} !== 14'h0) begin
            bad++;
            $display("FAIL reset_state rdy=%b vld=%b mean=%h sat=%0d required all 0",
                     in_ready, out_valid, out_mean, out_sat_count);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_exit in_ready=%b required=1", in_ready);
        end
    endtask

    // Eight 1.5 samples with out_ready already high during accumulation.
    task automatic test_basic();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(8'h18, 1'b0);
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mean !== 8'h18 || out_sat_count !== 4'd0) begin
            bad++;
            $display("FAIL basic_mean vld=%b rdy=%b mean=%h sat=%0d required 1 0 18 0",
                     out_valid, in_ready, out_mean, out_sat_count);
        end
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_release vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    // Rounding cases; the first block also toggles in_valid with junk on idle cycles.
    task automatic test_rounding();
        logic [7:0] exp_mean [3];
        exp_mean = '{8'h08, 8'h01, 8'h00};
        for (int i = 0; i < 4; i++) begin
            push(8'h10, 1'b0);
            in_result = 8'h77;
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) push(8'h00, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_mean !== exp_mean[0] || out_sat_count !== 4'd0) begin
            bad++;
            $display("FAIL round_half vld=%b mean=%h sat=%0d required 1 %h 0",
                     out_valid, out_mean, out_sat_count, exp_mean[0]);
        end
        take();
        push(8'h04, 1'b0);
        for (int i = 0; i < 7; i++) push(8'h00, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_mean !== exp_mean[1]) begin
            bad++;
            $display("FAIL round_up vld=%b mean=%h required 1 %h", out_valid, out_mean, exp_mean[1]);
        end
        take();
        push(8'hFC, 1'b0);
        for (int i = 0; i < 7; i++) push(8'h00, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_mean !== exp_mean[2]) begin
            bad++;
            $display("FAIL round_neg_tie vld=%b mean=%h required 1 %h", out_valid, out_mean, exp_mean[2]);
        end
        take();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) push(8'h80, 1'b1);
        total++;
        if (out_mean !== 8'h7F || out_sat_count !== 4'd8) begin
            bad++;
            $display("FAIL sat_pos mean=%h sat=%0d required 7f 8", out_mean, out_sat_count);
        end
        take();
        for (int i = 0; i < 8; i++) push(8'h7F, 1'b1);
        total++;
        if (out_mean !== 8'h80 || out_sat_count !== 4'd8) begin
            bad++;
            $display("FAIL sat_neg mean=%h sat=%0d required 80 8", out_mean, out_sat_count);
        end
        take();
        for (int i = 0; i < 4; i++) push(8'h80, 1'b1);
        for (int i = 0; i < 4; i++) push(8'h00, 1'b0);
        total++;
        if (out_mean !== 8'h40 || out_sat_count !== 4'd4) begin
            bad++;
            $display("FAIL sat_mixed mean=%h sat=%0d required 40 4", out_mean, out_sat_count);
        end
        take();
    endtask

    // Hold the result for five cycles with in_valid high, then confirm the next block is clean.
    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) push(8'h30, 1'b0);
        in_valid  = 1'b1;
        in_result = 8'h30;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_mean !== 8'h30 || out_sat_count !== 4'd0) begin
                bad++;
                $display("FAIL hold_cycle%0d rdy=%b vld=%b mean=%h sat=%0d required 0 1 30 0",
                         i, in_ready, out_valid, out_mean, out_sat_count);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        take();
        for (int i = 0; i < 8; i++) push(8'h08, 1'b0);
        total++;
        if (out_mean !== 8'h08 || out_sat_count !== 4'd0) begin
            bad++;
            $display("FAIL after_hold mean=%h sat=%0d required 08 0", out_mean, out_sat_count);
        end
        take();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) push(8'h7F, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid  = 1'b1;
        in_result = 8'h55;
        total++;
        if ({in_ready, out_valid, out_mean, out_sat_count} !== 14'h0) begin
            bad++;
            $display("FAIL mid_reset rdy=%b vld=%b mean=%h sat=%0d required all 0",
                     in_ready, out_valid, out_mean, out_sat_count);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_ready in_ready=%b required=1", in_ready);
        end
        for (int i = 0; i < 8; i++) push(8'h20, 1'b0);
        total++;
        if (out_mean !== 8'h20 || out_sat_count !== 4'd0) begin
            bad++;
            $display("FAIL mid_reset_block mean=%h sat=%0d required 20 0", out_mean, out_sat_count);
        end
        take();
    endtask

    task automatic test_reset_hold();
        for (int i = 0; i < 8; i++) push(8'h10, i[0]);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_hold out_valid=%b required=1", out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b0 || out_mean !== 8'h00 || out_sat_count !== 4'd0) begin
            bad++;
            $display("FAIL hold_reset vld=%b mean=%h sat=%0d required 0 00 0",
                     out_valid, out_mean, out_sat_count);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL hold_lost%0d vld=%b rdy=%b required 0 1", i, out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_reset_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
